fifo_sync_levels: RTL
=====================

FIFO_SYNC_LEVELS -- requirements
Module: fifo_sync_levels

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of stored words (>=2, any integer, not restricted to powers of two).
REQ-003 SHALL have parameter ALMOST_FULL_LEVEL, default DEPTH-1, count at or above which o_AlmostFull asserts (1..DEPTH).
REQ-004 SHALL have parameter ALMOST_EMPTY_LEVEL, default 1, count at or below which o_AlmostEmpty asserts (0..DEPTH-1).
REQ-005 SHALL have ports: i_Clock in 1, single clock, all logic on rising edge.
REQ-006 SHALL have i_Reset in 1, synchronous, active-high reset.
REQ-007 SHALL have i_WrData in DATA_WIDTH, write word; i_WrEnable in 1, write request.
REQ-008 SHALL have o_RdData out DATA_WIDTH, read word; i_RdEnable in 1, read request.
REQ-009 SHALL have o_IsFull, o_IsEmpty, o_AlmostFull, o_AlmostEmpty out 1, status flags.
REQ-010 SHALL have o_Count out $clog2(DEPTH+1), current occupancy.
REQ-011 SHALL have o_Overflow, o_Underflow out 1, sticky error flags; i_ClearErrors in 1, clears both.

Function
REQ-012 SHALL accept a write on a rising edge iff i_WrEnable=1 and o_IsFull=0; accepted word stored at write pointer.
REQ-013 SHALL accept a read on a rising edge iff i_RdEnable=1 and o_IsEmpty=0; read pointer advances.
REQ-014 SHALL support an accepted write and an accepted read in the same cycle; o_Count unchanged.
REQ-015 SHALL treat each cycle with enable high as one request (level-sensitive, no lock/edge detect); N consecutive enabled cycles = N transfers.
REQ-016 SHALL wrap each pointer from DEPTH-1 to 0; pointers never reach DEPTH.
REQ-017 SHALL update o_Count: +1 write-only, -1 read-only, unchanged for both or neither; range 0..DEPTH.
REQ-018 SHALL drive o_IsFull = (o_Count==DEPTH), o_IsEmpty = (o_Count==0), o_AlmostFull = (o_Count>=ALMOST_FULL_LEVEL), o_AlmostEmpty = (o_Count<=ALMOST_EMPTY_LEVEL), all from registered state.
REQ-019 SHALL, when full with i_WrEnable=1 and i_RdEnable=1, accept the read only, reject the write; flags reflect full at decision time.
REQ-020 SHALL, when empty with i_WrEnable=1 and i_RdEnable=1, accept the write only, reject the read; no bypass.
REQ-021 SHALL set o_Overflow on the edge following a rejected write and o_Underflow following a rejected read; flags hold until i_ClearErrors or reset.
REQ-022 SHALL give a same-cycle error event priority over i_ClearErrors (flag stays 1).
REQ-023 SHALL leave storage, pointers and o_RdData unchanged by rejected requests.
REQ-024 SHALL, in registered mode, load o_RdData with the head word on the edge accepting a read (1-cycle latency) and otherwise hold it.

Reset
REQ-025 SHALL on i_Reset=1 at a rising edge set pointers 0, o_Count 0, o_Overflow 0, o_Underflow 0, o_RdData 0, regardless of other inputs, including mid-transfer.
REQ-026 SHALL consequently show o_IsEmpty=1, o_IsFull=0, o_AlmostEmpty=1, o_AlmostFull=(ALMOST_FULL_LEVEL==0 ? n/a : 0) after reset; storage contents need not be cleared.

Configuration
REQ-027 SHALL compile first-word-fall-through when macro FIFO_SYNC_LEVELS_FWFT_EN is defined: o_RdData continuously shows the head word (0-cycle latency), i_RdEnable pops it; o_RdData undefined-but-stable (held last value) while empty.
REQ-028 SHALL, without FIFO_SYNC_LEVELS_FWFT_EN, use registered mode per REQ-024; all other requirements identical in both modes.

Verification (DATA_WIDTH=8, DEPTH=5, ALMOST_FULL_LEVEL=4, ALMOST_EMPTY_LEVEL=1)
REQ-029 SHALL cover fill/drain: write 0x11..0x55 over 5 cycles -> o_Count 5, o_IsFull=1, o_AlmostFull from count 4; read 5 -> 0x11..0x55 in order, o_IsEmpty=1.
REQ-030 SHALL cover wrap: write 3, read 3, write 5, read 5 -> data order preserved across pointer wrap 4->0, no error flags.
REQ-031 SHALL cover simultaneous: count 2, both enables for 4 cycles -> count stays 2, 4 words out in order; at full with both -> count 4, o_Overflow=1.
REQ-032 SHALL cover underflow: empty, i_RdEnable=1 one cycle -> o_Underflow=1, o_Count 0, o_RdData unchanged; i_ClearErrors=1 -> 0.
REQ-033 SHALL cover reset mid-operation: count 3, i_Reset=1 with i_WrEnable=1 -> count 0, o_IsEmpty=1, write discarded.
REQ-034 SHALL cover FWFT build: write 0xA5 -> o_RdData=0xA5 next cycle without read; i_RdEnable=1 -> empty, no extra latency.

Source files
------------

// File: rtl/fifo_sync_levels.sv
// Synchronous FIFO with occupancy count, programmable almost-full/almost-empty levels and sticky errors.
// Define FIFO_SYNC_LEVELS_FWFT_EN for first-word-fall-through reads; otherwise reads are registered.
module fifo_sync_levels #(
  parameter int DATA_WIDTH         = 8,
  parameter int DEPTH              = 4,
  parameter int ALMOST_FULL_LEVEL  = DEPTH - 1,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset,
  input  logic [DATA_WIDTH-1:0]        i_WrData,
  input  logic                         i_WrEnable,
  output logic [DATA_WIDTH-1:0]        o_RdData,
  input  logic                         i_RdEnable,
  output logic                         o_IsFull,
  output logic                         o_IsEmpty,
  output logic                         o_AlmostFull,
  output logic                         o_AlmostEmpty,
  output logic [$clog2(DEPTH+1)-1:0]   o_Count,
  output logic                         o_Overflow,
  output logic                         o_Underflow,
  input  logic                         i_ClearErrors
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  wr_ok, rd_ok;

  assign o_Count       = count;
  assign o_IsFull      = (count == CW'(DEPTH));
  assign o_IsEmpty     = (count == '0);
  assign o_AlmostFull  = (count >= CW'(ALMOST_FULL_LEVEL));
  assign o_AlmostEmpty = (count <= CW'(ALMOST_EMPTY_LEVEL));

  // Acceptance uses the registered full/empty state, so full+both pops only and empty+both pushes only.
  assign wr_ok = i_WrEnable & ~o_IsFull;
  assign rd_ok = i_RdEnable & ~o_IsEmpty;

  always_ff @(posedge i_Clock) begin
    if (wr_ok && !i_Reset) mem[wr_ptr] <= i_WrData;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // An error in the same cycle as a clear wins: the flag stays set.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Overflow  <= 1'b0;
      o_Underflow <= 1'b0;
    end else begin
      if (i_WrEnable && o_IsFull)      o_Overflow <= 1'b1;
      else if (i_ClearErrors)          o_Overflow <= 1'b0;
      if (i_RdEnable && o_IsEmpty)     o_Underflow <= 1'b1;
      else if (i_ClearErrors)          o_Underflow <= 1'b0;
    end
  end

`ifdef FIFO_SYNC_LEVELS_FWFT_EN
  // Head word shown directly; while empty, the last popped word is held.
  logic [DATA_WIDTH-1:0] hold;

  always_ff @(posedge i_Clock) begin
    if (i_Reset)    hold <= '0;
    else if (rd_ok) hold <= mem[rd_ptr];
  end

  assign o_RdData = o_IsEmpty ? hold : mem[rd_ptr];
`else
  always_ff @(posedge i_Clock) begin
    if (i_Reset)    o_RdData <= '0;
    else if (rd_ok) o_RdData <= mem[rd_ptr];
  end
`endif

endmodule
